// File: rtl/cgra_exec_controller_pkg.sv
// Shared constants, types and helpers for the CGRA execution controller.
// Optional feature macro: CGRA_EXEC_CONTROLLER_PERF_EN (adds exec_cycle_count).
package cgra_exec_controller_pkg;

  localparam int PE_NUM                  = 16;
  localparam int PE_ID_WIDTH             = $clog2(PE_NUM);
  localparam int CONTEXT_SIZE            = 8;
  localparam int CONTEXT_SIZE_BIT_LENGTH = $clog2(CONTEXT_SIZE);
  localparam int INPUT_NUM_BIT_LENGTH    = 3;
  localparam int OPERATION_BIT_LENGTH    = 4;
  localparam int DATA_WIDTH              = 32;
  localparam int CONTEXT_SWITCH_CLK_SIZE = 3;
  localparam int ITER_WIDTH              = 16;
  localparam int PERIOD_WIDTH            = CONTEXT_SIZE_BIT_LENGTH + 4;
  localparam int PERF_WIDTH              = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_RUN,
    ST_DONE
  } ctrl_state_t;

  typedef struct packed {
    logic [PE_ID_WIDTH-1:0]             pe_id;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0] context_id;
    logic [INPUT_NUM_BIT_LENGTH-1:0]    index_1;
    logic [INPUT_NUM_BIT_LENGTH-1:0]    index_2;
    logic [OPERATION_BIT_LENGTH-1:0]    op;
    logic [DATA_WIDTH-1:0]              const_data;
    logic                               last;
  } config_word_t;

  // Cycles in one full context loop: (max_id+1) contexts of SWITCH+1 cycles each.
  function automatic logic [PERIOD_WIDTH-1:0] period_len(
    input logic [CONTEXT_SIZE_BIT_LENGTH-1:0] max_id
  );
    return (PERIOD_WIDTH'(max_id) + PERIOD_WIDTH'(1)) *
           PERIOD_WIDTH'(CONTEXT_SWITCH_CLK_SIZE + 1);
  endfunction

  // Fields are widened by one bit so the bounds stay meaningful for any PE count.
  function automatic logic word_in_range(input config_word_t w, input int pe_count);
    return ({1'b0, w.pe_id} < (PE_ID_WIDTH + 1)'(pe_count)) &&
           ({1'b0, w.context_id} < (CONTEXT_SIZE_BIT_LENGTH + 1)'(CONTEXT_SIZE));
  endfunction

endpackage

// File: rtl/cgra_exec_controller_if.sv
// Host/config stream, run control and PE config bus of the CGRA execution controller.
// Optional macro CGRA_EXEC_CONTROLLER_PERF_EN adds exec_cycle_count.
interface cgra_exec_controller_if #(
  parameter int PE_COUNT = cgra_exec_controller_pkg::PE_NUM
) ();
  import cgra_exec_controller_pkg::*;

  logic                               cfg_valid;
  logic                               cfg_ready;
  logic [PE_ID_WIDTH-1:0]             cfg_pe_id;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] cfg_context_id;
  logic [INPUT_NUM_BIT_LENGTH-1:0]    cfg_input_index_1;
  logic [INPUT_NUM_BIT_LENGTH-1:0]    cfg_input_index_2;
  logic [OPERATION_BIT_LENGTH-1:0]    cfg_op;
  logic [DATA_WIDTH-1:0]              cfg_const;
  logic                               cfg_last;

  logic                               run_req;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] run_max_context_id;
  logic [ITER_WIDTH-1:0]              run_iterations;
  logic                               abort;

  logic [INPUT_NUM_BIT_LENGTH-1:0]    pe_config_input_PE_index_1;
  logic [INPUT_NUM_BIT_LENGTH-1:0]    pe_config_input_PE_index_2;
  logic [OPERATION_BIT_LENGTH-1:0]    pe_config_op;
  logic [DATA_WIDTH-1:0]              pe_config_const_data;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] pe_config_index;
  logic [PE_COUNT-1:0]                pe_write_config_data;
  logic                               start_exec;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] mapping_context_max_id;
  logic                               busy;
  logic                               done;
  logic                               cfg_error;
`ifdef CGRA_EXEC_CONTROLLER_PERF_EN
  logic [PERF_WIDTH-1:0]              exec_cycle_count;
`endif

  modport master (
    output cfg_valid, cfg_pe_id, cfg_context_id, cfg_input_index_1, cfg_input_index_2,
           cfg_op, cfg_const, cfg_last, run_req, run_max_context_id, run_iterations, abort,
`ifdef CGRA_EXEC_CONTROLLER_PERF_EN
    input  exec_cycle_count,
`endif
    input  cfg_ready, pe_config_input_PE_index_1, pe_config_input_PE_index_2, pe_config_op,
           pe_config_const_data, pe_config_index, pe_write_config_data, start_exec,
           mapping_context_max_id, busy, done, cfg_error
  );

  modport slave (
    input  cfg_valid, cfg_pe_id, cfg_context_id, cfg_input_index_1, cfg_input_index_2,
           cfg_op, cfg_const, cfg_last, run_req, run_max_context_id, run_iterations, abort,
`ifdef CGRA_EXEC_CONTROLLER_PERF_EN
    output exec_cycle_count,
`endif
    output cfg_ready, pe_config_input_PE_index_1, pe_config_input_PE_index_2, pe_config_op,
           pe_config_const_data, pe_config_index, pe_write_config_data, start_exec,
           mapping_context_max_id, busy, done, cfg_error
  );

endinterface

// File: rtl/cgra_exec_controller_iter.sv
// RUN-phase loop timing: a reloading down-counter per context loop plus an
// iteration tally that raises term_o in the last cycle of the final loop.
module cgra_iteration_counter
  import cgra_exec_controller_pkg::*;
(
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               load_i,
  input  logic                               en_i,
  input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] max_id_i,
  input  logic [ITER_WIDTH-1:0]              iter_limit_i,
  output logic                               term_o
);

  logic [PERIOD_WIDTH-1:0] reload_q;
  logic [PERIOD_WIDTH-1:0] remain_q;
  logic [ITER_WIDTH-1:0]   iter_q;
  logic [ITER_WIDTH-1:0]   limit_q;
  logic                    wrap;

  assign wrap = en_i && (remain_q == '0);

  // A zero limit never terminates; such a run only ends on abort.
  assign term_o = wrap && (limit_q != '0) && ((iter_q + ITER_WIDTH'(1)) == limit_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reload_q <= '0;
      remain_q <= '0;
      iter_q   <= '0;
      limit_q  <= '0;
    end else if (load_i) begin
      reload_q <= period_len(max_id_i) - PERIOD_WIDTH'(1);
      remain_q <= period_len(max_id_i) - PERIOD_WIDTH'(1);
      iter_q   <= '0;
      limit_q  <= iter_limit_i;
    end else if (en_i) begin
      if (wrap) begin
        remain_q <= reload_q;
        iter_q   <= iter_q + ITER_WIDTH'(1);
      end else begin
        remain_q <= remain_q - PERIOD_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/cgra_exec_controller.sv
// Config-stream to PE-bus sequencer with start/run/done execution control.
// Optional macro CGRA_EXEC_CONTROLLER_PERF_EN adds the exec_cycle_count counter.
//
// state    | meaning
// ST_IDLE  | accepts config words or a run request
// ST_LOAD  | multi-word load in progress, run_req ignored
// ST_START | one-cycle start_exec, latches max id and loop count
// ST_RUN   | counting context loops until done or abort
// ST_DONE  | one-cycle done pulse
module cgra_exec_controller
  import cgra_exec_controller_pkg::*;
#(
  parameter int PE_COUNT = PE_NUM
) (
  input logic                   clk,
  input logic                   reset_n,
  cgra_exec_controller_if.slave ctrl
);

  ctrl_state_t state_q, state_d;
  config_word_t word;
  logic cfg_fire;
  logic word_ok;
  logic iter_term;

  logic                               cfg_ready_q;
  logic                               busy_q;
  logic                               start_exec_q;
  logic                               done_q;
  logic                               cfg_error_q;
  logic [PE_COUNT-1:0]                strobe_q;
  logic [INPUT_NUM_BIT_LENGTH-1:0]    idx_1_q;
  logic [INPUT_NUM_BIT_LENGTH-1:0]    idx_2_q;
  logic [OPERATION_BIT_LENGTH-1:0]    op_q;
  logic [DATA_WIDTH-1:0]              const_q;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] ctx_q;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] max_id_q;

  assign word = '{pe_id:      ctrl.cfg_pe_id,
                  context_id: ctrl.cfg_context_id,
                  index_1:    ctrl.cfg_input_index_1,
                  index_2:    ctrl.cfg_input_index_2,
                  op:         ctrl.cfg_op,
                  const_data: ctrl.cfg_const,
                  last:       ctrl.cfg_last};

  assign cfg_fire = ctrl.cfg_valid && cfg_ready_q;
  assign word_ok  = word_in_range(word, PE_COUNT);

  // A run may only start once the bus is quiet: no word this cycle, no strobe in flight.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_fire) begin
          state_d = word.last ? ST_IDLE : ST_LOAD;
        end else if (ctrl.run_req && (strobe_q == '0)) begin
          state_d = ST_START;
        end
      end
      ST_LOAD:  if (cfg_fire && word.last) state_d = ST_IDLE;
      ST_START: state_d = ST_RUN;
      ST_RUN:   if (ctrl.abort || iter_term) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cfg_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      start_exec_q <= 1'b0;
      done_q       <= 1'b0;
      cfg_error_q  <= 1'b0;
      strobe_q     <= '0;
      idx_1_q      <= '0;
      idx_2_q      <= '0;
      op_q         <= '0;
      const_q      <= '0;
      ctx_q        <= '0;
      max_id_q     <= '0;
    end else begin
      state_q      <= state_d;
      cfg_ready_q  <= (state_d == ST_IDLE) || (state_d == ST_LOAD);
      busy_q       <= (state_d != ST_IDLE);
      start_exec_q <= (state_d == ST_START);
      done_q       <= (state_d == ST_DONE);
      strobe_q     <= '0;
      if (cfg_fire) begin
        idx_1_q <= word.index_1;
        idx_2_q <= word.index_2;
        op_q    <= word.op;
        const_q <= word.const_data;
        ctx_q   <= word.context_id;
        if (word_ok) begin
          strobe_q <= PE_COUNT'(1) << word.pe_id;
        end else begin
          cfg_error_q <= 1'b1;
        end
      end
      if (state_q == ST_START) begin
        max_id_q <= ctrl.run_max_context_id;
      end
      if ((state_q == ST_IDLE) && (state_d == ST_START)) begin
        cfg_error_q <= 1'b0;
      end
    end
  end

  cgra_iteration_counter u_iter (
    .clk          (clk),
    .reset_n      (reset_n),
    .load_i       (state_q == ST_START),
    .en_i         (state_q == ST_RUN),
    .max_id_i     (ctrl.run_max_context_id),
    .iter_limit_i (ctrl.run_iterations),
    .term_o       (iter_term)
  );

`ifdef CGRA_EXEC_CONTROLLER_PERF_EN
  logic [PERF_WIDTH-1:0] perf_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_q <= '0;
    end else if (state_q == ST_START) begin
      perf_q <= '0;
    end else if ((state_q == ST_RUN) && (perf_q != '1)) begin
      perf_q <= perf_q + PERF_WIDTH'(1);
    end
  end

  assign ctrl.exec_cycle_count = perf_q;
`endif

  assign ctrl.cfg_ready                  = cfg_ready_q;
  assign ctrl.busy                       = busy_q;
  assign ctrl.start_exec                 = start_exec_q;
  assign ctrl.done                       = done_q;
  assign ctrl.cfg_error                  = cfg_error_q;
  assign ctrl.pe_write_config_data       = strobe_q;
  assign ctrl.pe_config_input_PE_index_1 = idx_1_q;
  assign ctrl.pe_config_input_PE_index_2 = idx_2_q;
  assign ctrl.pe_config_op               = op_q;
  assign ctrl.pe_config_const_data       = const_q;
  assign ctrl.pe_config_index            = ctx_q;
  assign ctrl.mapping_context_max_id     = max_id_q;

endmodule

// File: tb/tb_cgra_exec_controller.sv
// Directed plus randomized bench for cgra_exec_controller; the PE count is reduced
// to 12 so that out-of-range PE ids are representable on the 4-bit select.
`timescale 1ns/1ps
module tb_cgra_exec_controller;
  import cgra_exec_controller_pkg::*;

  localparam int PE_CNT = 12;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  cgra_exec_controller_if #(.PE_COUNT(PE_CNT)) ifc ();

  cgra_exec_controller #(.PE_COUNT(PE_CNT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ctrl    (ifc)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int start_cnt = 0;
  bit err_exp = 1'b0;

  always @(negedge clk) if (ifc.start_exec === 1'b1) start_cnt++;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: one-hot strobe one cycle after acceptance, none for an out-of-range PE.
  task automatic send_word(input int pe, input int ctx, input int i1, input int i2,
                           input int op, input logic [31:0] cst, input bit last);
    int guard;
    logic [63:0] exp_strobe;
    ifc.cfg_pe_id         = PE_ID_WIDTH'(pe);
    ifc.cfg_context_id    = CONTEXT_SIZE_BIT_LENGTH'(ctx);
    ifc.cfg_input_index_1 = INPUT_NUM_BIT_LENGTH'(i1);
    ifc.cfg_input_index_2 = INPUT_NUM_BIT_LENGTH'(i2);
    ifc.cfg_op            = OPERATION_BIT_LENGTH'(op);
    ifc.cfg_const         = cst;
    ifc.cfg_last          = last;
    ifc.cfg_valid         = 1'b1;
    guard = 0;
    while (ifc.cfg_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    check("cfg_ready_wait", 64'(ifc.cfg_ready), 64'(1));
    tick();
    ifc.cfg_valid = 1'b0;
    ifc.cfg_last  = 1'b0;
    if (pe < PE_CNT) exp_strobe = 64'd1 << pe;
    else begin
      exp_strobe = 64'd0;
      err_exp = 1'b1;
    end
    check("strobe", 64'(ifc.pe_write_config_data), exp_strobe);
    if (pe < PE_CNT)
      check("bus_fields",
            64'({ifc.pe_config_input_PE_index_1, ifc.pe_config_input_PE_index_2,
                 ifc.pe_config_op, ifc.pe_config_const_data, ifc.pe_config_index}),
            64'({3'(i1), 3'(i2), 4'(op), cst, 3'(ctx)}));
    check("cfg_error", 64'(ifc.cfg_error), 64'(err_exp));
    check("busy_cfg", 64'(ifc.busy), 64'(!last));
    tick();
    check("strobe_off", 64'(ifc.pe_write_config_data), 64'd0);
  endtask

  // Reference: a run lasts iters*(max_id+1)*(SWITCH+1) RUN cycles, or abort_at
  // cycles when aborted; done follows the last RUN cycle.
  task automatic run_job(input int max_id, input int iters, input int abort_at,
                         input int exp_lat, input string tag);
    int guard;
    int runc;
    int exp_run;
    int busy_low;
    ifc.run_max_context_id = CONTEXT_SIZE_BIT_LENGTH'(max_id);
    ifc.run_iterations     = ITER_WIDTH'(iters);
    ifc.run_req            = 1'b1;
    guard = 0;
    while (ifc.start_exec !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    ifc.run_req = 1'b0;
    check({tag, "_start_lat"}, 64'(guard), 64'(exp_lat));
    check({tag, "_start"}, 64'(ifc.start_exec), 64'(1));
    check({tag, "_busy_start"}, 64'(ifc.busy), 64'(1));
    err_exp = 1'b0;
    check({tag, "_err_clr"}, 64'(ifc.cfg_error), 64'(err_exp));
    tick();
    check({tag, "_start_pulse"}, 64'(ifc.start_exec), 64'(0));
    check({tag, "_max_id"}, 64'(ifc.mapping_context_max_id), 64'(max_id));
    exp_run = (abort_at > 0) ? abort_at : iters * (max_id + 1) * (CONTEXT_SWITCH_CLK_SIZE + 1);
    runc = 1;
    busy_low = 0;
    while (ifc.done !== 1'b1 && runc < 3000) begin
      if (ifc.busy !== 1'b1) busy_low++;
      if (runc == abort_at) ifc.abort = 1'b1;
      tick();
      runc++;
      ifc.abort = 1'b0;
    end
    check({tag, "_done_cycles"}, 64'(runc), 64'(exp_run + 1));
    check({tag, "_done"}, 64'(ifc.done), 64'(1));
    check({tag, "_busy_run"}, 64'(busy_low), 64'(0));
`ifdef CGRA_EXEC_CONTROLLER_PERF_EN
    check({tag, "_perf"}, 64'(ifc.exec_cycle_count), 64'(exp_run));
`endif
    tick();
    check({tag, "_done_pulse"}, 64'(ifc.done), 64'(0));
    check({tag, "_idle"}, 64'({ifc.busy, ifc.cfg_ready}), 64'(2'b01));
    check({tag, "_max_id_hold"}, 64'(ifc.mapping_context_max_id), 64'(max_id));
`ifdef CGRA_EXEC_CONTROLLER_PERF_EN
    check({tag, "_perf_hold"}, 64'(ifc.exec_cycle_count), 64'(exp_run));
`endif
  endtask

  initial begin
    int s0;
    int nw;
    int mx;
    int it;
    int ab;
    int per;
    ifc.cfg_valid = 1'b0; ifc.cfg_pe_id = '0; ifc.cfg_context_id = '0;
    ifc.cfg_input_index_1 = '0; ifc.cfg_input_index_2 = '0; ifc.cfg_op = '0;
    ifc.cfg_const = '0; ifc.cfg_last = 1'b0; ifc.run_req = 1'b0;
    ifc.run_max_context_id = '0; ifc.run_iterations = '0; ifc.abort = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", 64'({ifc.busy, ifc.done, ifc.start_exec, ifc.cfg_ready, ifc.cfg_error,
                           ifc.mapping_context_max_id, ifc.pe_write_config_data}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("rst_ready", 64'({ifc.cfg_ready, ifc.busy}), 64'(2'b10));

    send_word(2, 0, 1, 2, 1, 32'h0, 1'b0);
    send_word(5, 1, 3, 4, 5, 32'h1234, 1'b0);
    send_word(0, 3, 6, 7, 8, 32'hA5A5_0001, 1'b1);

    // abort outside RUN must have no effect
    ifc.abort = 1'b1;
    tick();
    ifc.abort = 1'b0;
    check("abort_idle", 64'({ifc.busy, ifc.done, ifc.start_exec}), 64'd0);

    send_word(PE_CNT, 2, 1, 1, 2, 32'hDEAD, 1'b1);
    send_word(4, 6, 2, 3, 9, 32'h55, 1'b1);
    run_job(2, 4, 0, 1, "main48");

    // run_req raised together with a word, then held through LOAD and the trailing strobe
    s0 = start_cnt;
    ifc.run_max_context_id = 3'd1;
    ifc.run_iterations     = 16'd2;
    ifc.run_req            = 1'b1;
    send_word(7, 2, 1, 2, 3, 32'hCAFE, 1'b0);
    send_word(9, 4, 4, 5, 6, 32'hBEEF, 1'b0);
    send_word(11, 7, 7, 0, 15, 32'h1, 1'b1);
    check("blk_no_start", 64'(start_cnt - s0), 64'd0);
    tick();
    check("blk_start_quiet", 64'(ifc.start_exec), 64'(1));
    run_job(1, 2, 0, 0, "blk");

    run_job(5, 0, 100, 1, "abort100");
    run_job(0, 1, 4, 1, "abort_at_term");
    run_job(0, 1, 0, 1, "min_period");
    run_job(7, 1, 0, 1, "max_period");

    for (int k = 0; k < 6; k++) begin
      nw = int'($urandom_range(1, 3));
      for (int w = 0; w < nw; w++)
        send_word(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 15)), $urandom, w == nw - 1);
      mx  = int'($urandom_range(0, 7));
      it  = int'($urandom_range(1, 3));
      per = (mx + 1) * (CONTEXT_SWITCH_CLK_SIZE + 1);
      ab  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, it * per)) : 0;
      run_job(mx, it, ab, 1, "rand");
    end

    // reset dropped in the middle of an endless run
    ifc.run_max_context_id = 3'd5;
    ifc.run_iterations     = 16'd0;
    ifc.run_req            = 1'b1;
    tick();
    ifc.run_req = 1'b0;
    check("mid_start", 64'(ifc.start_exec), 64'(1));
    repeat (20) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_ctrl", 64'({ifc.busy, ifc.done, ifc.start_exec, ifc.cfg_ready, ifc.cfg_error,
                               ifc.mapping_context_max_id, ifc.pe_write_config_data}), 64'd0);
    check("mid_rst_bus", 64'({ifc.pe_config_input_PE_index_1, ifc.pe_config_input_PE_index_2,
                              ifc.pe_config_op, ifc.pe_config_const_data, ifc.pe_config_index}),
          64'd0);
`ifdef CGRA_EXEC_CONTROLLER_PERF_EN
    check("mid_rst_perf", 64'(ifc.exec_cycle_count), 64'd0);
`endif
    err_exp = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("post_rst_ready", 64'(ifc.cfg_ready), 64'(1));
    run_job(1, 2, 0, 1, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
